seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential unsigned restoring divider, one quotient bit per cycle.
//  Inverse of the 19x19 array multiplier: takes a 2N-bit product and an N-bit
//  divisor, returns an N-bit quotient and an N-bit remainder.
//  Used for multiply/divide round-trip checking and as the datapath divide unit.
//  Valid/ready handshake on both the operand side and the result side.
// PARAMETERS
//  N  19  divisor/quotient/remainder width; dividend width is 2N
// PORTS
//  clk        in   1    rising-edge clock
//  reset_n    in   1    asynchronous active-low reset
//  in_valid   in   1    operands valid
//  in_ready   out  1    divider idle, can accept operands
//  dividend   in   2N   unsigned dividend
//  divisor    in   N    unsigned divisor
//  out_valid  out  1    result valid; held until accepted
//  out_ready  in   1    consumer accepts result
//  quotient   out  N    unsigned quotient
//  remainder  out  N    unsigned remainder
//  div_zero   out  1    divisor was 0
//  overflow   out  1    quotient does not fit in N bits
// BEHAVIOUR
//  Reset: async on reset_n low, from any state. State=IDLE; in_ready=1,
//   out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0, count=0.
//  FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  IDLE: operands are accepted on an edge with in_valid && in_ready.
//   divisor==0          -> DONE; div_zero=1, quotient=all ones, remainder=0.
//   else dividend[2N-1:N] >= divisor -> DONE; overflow=1, quotient=all ones,
//                          remainder=0.
//   else -> RUN; rem=dividend[2N-1:N], q=dividend[N-1:0], count=N.
//   div_zero has priority over overflow.
//  RUN: one step per edge:
//   trial = {rem, q[N-1]} - {1'b0, divisor}   (N+1 bits)
//   If trial MSB is 0: rem=trial[N-1:0], q={q[N-2:0],1}.
//   Else: rem={rem,q[N-1]}[N-1:0], q={q[N-2:0],0}.
//   count decrements. The step that brings count to 0 moves the FSM to DONE.
//  Latency: operands accepted at edge t.
//   Normal divide: out_valid high after edge t+N (19 cycles at default N).
//   Exception: out_valid high after edge t+1.
//  DONE: quotient, remainder and flags are stable while out_valid=1.
//   On an edge with out_ready=1 -> IDLE; flags clear, data outputs hold last value.
//   No new operand can be accepted in the same edge as the result is popped;
//    in_ready rises the cycle after.
//  in_valid while busy (RUN/DONE): ignored; the operand is not captured or queued.
//  Invariant: rem < divisor throughout RUN. Final quotient*divisor+remainder
//   equals dividend.
//  Reset mid-RUN: the operation is aborted; no out_valid pulse is produced.
// TESTING
//  1 dividend=35, divisor=7 -> 19 cycles after accept: quotient=5, remainder=0,
//    flags 0.
//  2 dividend=100, divisor=7 -> quotient=14, remainder=2.
//  3 dividend=(2^19-1)^2=274876858369, divisor=524287 -> quotient=524287,
//    remainder=0 (max product round-trip).
//  4 divisor=0, dividend=12345 -> div_zero=1 one cycle after accept,
//    quotient=0x7FFFF, remainder=0.
//  5 dividend=3*2^19, divisor=3 -> overflow=1 one cycle after accept.
//    dividend=3*2^19-1, divisor=3 -> no overflow, quotient=0x7FFFF, remainder=2.
//  6 out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0,
//    in_valid pulses ignored. Reset asserted at RUN step 10 -> out_valid=0,
//    in_ready=1 immediately.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, valid/ready handshake on operands and result.
module seq_divider #(
  parameter int N = 19
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(N);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  rem_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  divisor_reg;
  logic [CW-1:0] count_reg;

  logic [N:0]    trial;
  logic [N-1:0]  rem_step;
  logic [N-1:0]  q_step;
  logic          hi_ge_divisor;

  // q_reg doubles as the shift register for the low dividend half: its MSB
  // is shifted into the partial remainder while quotient bits enter at the LSB.
  assign trial    = {rem_reg, q_reg[N-1]} - {1'b0, divisor_reg};
  assign rem_step = trial[N] ? {rem_reg[N-2:0], q_reg[N-1]} : trial[N-1:0];
  assign q_step   = {q_reg[N-2:0], ~trial[N]};

  // A high half at or above the divisor means the quotient needs more than N bits.
  assign hi_ge_divisor = (dividend[2*N-1:N] >= divisor);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_zero    <= 1'b0;
      overflow    <= 1'b0;
      rem_reg     <= '0;
      q_reg       <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state_reg <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else if (hi_ge_divisor) begin
              state_reg <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
            end else begin
              state_reg   <= RUN;
              in_ready    <= 1'b0;
              rem_reg     <= dividend[2*N-1:N];
              q_reg       <= dividend[N-1:0];
              divisor_reg <= divisor;
              count_reg   <= COUNT_INIT;
            end
          end
        end
        RUN: begin
          rem_reg   <= rem_step;
          q_reg     <= q_step;
          count_reg <= count_reg - COUNT_ONE;
          if (count_reg == COUNT_ONE) begin
            state_reg <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_step;
            remainder <= rem_step;
          end
        end
        DONE: begin
          // Popping returns to IDLE; in_ready only rises after this edge.
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          div_zero  <= 1'b0;
          overflow  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, remainders, flags,
// latency, back-pressure hold and mid-run reset abort.
module tb_seq_divider;

  localparam int N = 19;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int n_checks;
  int n_fail;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present operands at a falling edge; they are taken on the next rising edge.
  task automatic accept(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    @(negedge clk);
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) check_eq("result_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("pop_out_valid", 64'(out_valid), 64'd0);
    check_eq("pop_in_ready", 64'(in_ready), 64'd1);
    check_eq("pop_flags", {62'd0, div_zero, overflow}, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                         input logic exp_dz, input logic exp_ov, input int exp_lat);
    int lat;
    accept(dd, dv);
    wait_result(lat);
    $display("txn %s: dividend=%0d divisor=%0d -> q=%0d r=%0d dz=%0b ov=%0b lat=%0d",
             tag, dd, dv, quotient, remainder, div_zero, overflow, lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_q"}, 64'(quotient), 64'(exp_q));
    check_eq({tag, "_r"}, 64'(remainder), 64'(exp_r));
    check_eq({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    check_eq({tag, "_ov"}, 64'(overflow), 64'(exp_ov));
    pop();
    check_eq({tag, "_q_hold"}, 64'(quotient), 64'(exp_q));
  endtask

  initial begin
    int lat;
    int stray;
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_quotient", 64'(quotient), 64'd0);
    check_eq("rst_remainder", 64'(remainder), 64'd0);
    check_eq("rst_flags", {62'd0, div_zero, overflow}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_div("t1_35_7",    38'd35,           19'd7,      19'd5,      19'd0, 1'b0, 1'b0, 19);
    run_div("t2_100_7",   38'd100,          19'd7,      19'd14,     19'd2, 1'b0, 1'b0, 19);
    run_div("t3_maxprod", 38'd274876858369, 19'd524287, 19'd524287, 19'd0, 1'b0, 1'b0, 19);
    run_div("t4_divzero", 38'd12345,        19'd0,      19'h7FFFF,  19'd0, 1'b1, 1'b0, 1);
    run_div("t5_ovf",     38'd1572864,      19'd3,      19'h7FFFF,  19'd0, 1'b0, 1'b1, 1);
    run_div("t5_noovf",   38'd1572863,      19'd3,      19'h7FFFF,  19'd2, 1'b0, 1'b0, 19);
    run_div("dz_prio",    38'd1572864,      19'd0,      19'h7FFFF,  19'd0, 1'b1, 1'b0, 1);
    run_div("t_one",      38'd524287,       19'd1,      19'd524287, 19'd0, 1'b0, 1'b0, 19);

    // Back-pressure: 1000/9 = 111 r 1 must hold while in_valid pulses are ignored.
    accept(38'd1000, 19'd9);
    wait_result(lat);
    check_eq("bp_lat", 64'(lat), 64'd19);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dividend = 38'd50;
      divisor  = 19'd5;
      in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_quotient", 64'(quotient), 64'd111);
      check_eq("bp_remainder", 64'(remainder), 64'd1);
    end
    in_valid = 1'b0;
    $display("txn bp_1000_9: q=%0d r=%0d held 5 cycles", quotient, remainder);
    pop();
    stray = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    check_eq("bp_no_queued_op", 64'(stray), 64'd0);
    run_div("after_bp_50_5", 38'd50, 19'd5, 19'd10, 19'd0, 1'b0, 1'b0, 19);

    // Asynchronous reset in the middle of a run aborts the operation.
    accept(38'd100, 19'd7);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_quotient", 64'(quotient), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    check_eq("midrst_no_pulse", 64'(stray), 64'd0);
    $display("txn midrst: operation aborted, out_valid pulses=%0d", stray);
    run_div("post_rst_35_7", 38'd35, 19'd7, 19'd5, 19'd0, 1'b0, 1'b0, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
